// File: rtl/dmem_arbiter.sv
// Round-robin data-memory arbiter between the core data port and the loader/DMA port,
// with a bounded burst lock and a one-cycle registered read response.
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          MemWrite,
    output logic [AW-1:0] DataAdr,
    output logic [DW-1:0] WriteData,
    input  logic [DW-1:0] ReadData,
    output logic [1:0]    owner
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] burst_cnt, cnt_nx, cnt_inc;
    logic          prio, prio_nx;
    logic          hold0, hold1;

    // The lock owner keeps the port until its budget runs out; after that
    // the normal round-robin choice applies, and prio already points away.
    assign hold0 = (state == LOCK0) && m0_req && (burst_cnt < MAXC);
    assign hold1 = (state == LOCK1) && m1_req && (burst_cnt < MAXC);

    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!reset) begin
            if (hold0) begin
                m0_gnt = 1'b1;
            end else if (hold1) begin
                m1_gnt = 1'b1;
            end else if (m0_req && m1_req) begin
                m0_gnt = !prio;
                m1_gnt = prio;
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end
    end

    assign owner = {m1_gnt, m0_gnt};

    always_comb begin
        MemWrite  = 1'b0;
        DataAdr   = '0;
        WriteData = '0;
        if (m0_gnt) begin
            MemWrite  = m0_we;
            DataAdr   = m0_addr;
            WriteData = m0_wdata;
        end else if (m1_gnt) begin
            MemWrite  = m1_we;
            DataAdr   = m1_addr;
            WriteData = m1_wdata;
        end
    end

    assign cnt_inc = (burst_cnt == MAXC) ? MAXC : burst_cnt + ONE;

    always_comb begin
        state_nx = IDLE;
        cnt_nx   = '0;
        prio_nx  = prio;
        if (m0_gnt) begin
            prio_nx = 1'b1;
            if (m0_lock) begin
                state_nx = LOCK0;
                cnt_nx   = (state == LOCK0) ? cnt_inc : ONE;
            end
        end else if (m1_gnt) begin
            prio_nx = 1'b0;
            if (m1_lock) begin
                state_nx = LOCK1;
                cnt_nx   = (state == LOCK1) ? cnt_inc : ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            burst_cnt <= '0;
            prio      <= 1'b0;
        end else begin
            state     <= state_nx;
            burst_cnt <= cnt_nx;
            prio      <= prio_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= m0_gnt && !m0_we;
            m1_rvalid <= m1_gnt && !m1_we;
            if (m0_gnt && !m0_we) begin
                m0_rdata <= ReadData;
            end
            if (m1_gnt && !m1_we) begin
                m1_rdata <= ReadData;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against an
// arbitration/memory reference model.
module tb_dmem_arbiter;

    localparam int MB = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rq[2];
    logic        we[2];
    logic        lk[2];
    logic [31:0] ad[2];
    logic [31:0] wd[2];

    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, MemWrite;
    logic [31:0] m0_rdata, m1_rdata, DataAdr, WriteData, ReadData;
    logic [1:0]  owner;

    logic [31:0] mem[16];
    assign ReadData = mem[DataAdr[5:2]];

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset),
        .m0_req(rq[0]), .m0_we(we[0]), .m0_lock(lk[0]),
        .m0_addr(ad[0]), .m0_wdata(wd[0]),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(rq[1]), .m1_we(we[1]), .m1_lock(lk[1]),
        .m1_addr(ad[1]), .m1_wdata(wd[1]),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .ReadData(ReadData), .owner(owner)
    );

    // Reference model: who is preferred, who holds a lock, how many beats it has had.
    int          m_prio;
    int          m_own;
    int          m_cnt;
    logic [31:0] mm[16];
    bit          e_rv[2];
    logic [31:0] e_rd[2];
    int          last_g;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        int          g;
        logic        ew;
        logic [31:0] ea, ed;
        logic        wr_c;
        logic [31:0] wa, wdv;
        @(negedge clk);
        g = -1;
        if (!reset) begin
            if (m_own >= 0 && rq[m_own] && m_cnt < MB) g = m_own;
            else if (rq[0] && rq[1]) g = m_prio;
            else if (rq[0]) g = 0;
            else if (rq[1]) g = 1;
        end
        ew = (g >= 0) ? we[g] : 1'b0;
        ea = (g >= 0) ? ad[g] : 32'h0;
        ed = (g >= 0) ? wd[g] : 32'h0;
        check("m0_gnt", m0_gnt, g == 0);
        check("m1_gnt", m1_gnt, g == 1);
        check("owner", owner, {g == 1, g == 0});
        check("MemWrite", MemWrite, ew);
        check("DataAdr", DataAdr, ea);
        check("WriteData", WriteData, ed);
        check("m0_rvalid", m0_rvalid, e_rv[0]);
        check("m1_rvalid", m1_rvalid, e_rv[1]);
        check("m0_rdata", m0_rdata, e_rd[0]);
        check("m1_rdata", m1_rdata, e_rd[1]);
        wr_c = MemWrite;
        wa   = DataAdr;
        wdv  = WriteData;
        @(posedge clk);
        #1;
        if (wr_c) mem[wa[5:2]] = wdv;
        last_g = g;
        if (reset) begin
            m_prio = 0;
            m_own  = -1;
            m_cnt  = 0;
            e_rv   = '{0, 0};
            e_rd   = '{32'h0, 32'h0};
        end else begin
            e_rv = '{0, 0};
            if (g < 0) begin
                m_own = -1;
                m_cnt = 0;
            end else begin
                if (we[g]) mm[ad[g][5:2]] = wd[g];
                else begin
                    e_rv[g] = 1;
                    e_rd[g] = mm[ad[g][5:2]];
                end
                m_prio = 1 - g;
                if (!lk[g]) begin
                    m_own = -1;
                    m_cnt = 0;
                end else if (m_own == g) begin
                    m_cnt = (m_cnt < MB) ? m_cnt + 1 : MB;
                end else begin
                    m_own = g;
                    m_cnt = 1;
                end
            end
        end
    endtask

    task automatic drive(input int i, input bit r, input bit w, input bit l,
                         input logic [31:0] a, input logic [31:0] d);
        rq[i] = r;
        we[i] = w;
        lk[i] = l;
        ad[i] = a;
        wd[i] = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    int gl[10];

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i] = 32'h01010101 * i;
            mm[i]  = 32'h01010101 * i;
        end
        mem[4] = 32'hDEADBEEF;
        mm[4]  = 32'hDEADBEEF;
        m_prio = 0;
        m_own  = -1;
        m_cnt  = 0;
        e_rv   = '{0, 0};
        e_rd   = '{32'h0, 32'h0};
        last_g = -1;
        drive(0, 1, 0, 1, 32'h10, 32'h0);
        drive(1, 1, 1, 1, 32'h20, 32'h1);
        @(posedge clk);
        #1;
        step();
        step();
        check("gnt_in_reset", last_g, -1);
        drive(1, 0, 0, 0, 32'h0, 32'h0);
        drive(0, 1, 0, 0, 32'h10, 32'h0);
        reset = 1'b0;
        step();
        check("rd10_gnt", last_g, 0);
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        step();
        check("rd10_data", m0_rdata, 32'hDEADBEEF);
        check("rd10_m1", m1_rdata, 32'h0);

        do_reset();
        drive(0, 1, 0, 0, 32'h4, 32'h0);
        drive(1, 1, 0, 0, 32'h8, 32'h0);
        for (int c = 0; c < 4; c++) begin
            step();
            check("alt", last_g, c % 2);
        end

        drive(1, 0, 0, 0, 32'h0, 32'h0);
        step();
        drive(0, 1, 0, 0, 32'h20, 32'h0);
        drive(1, 1, 1, 0, 32'h20, 32'h55);
        step();
        check("wr_first", last_g, 1);
        drive(1, 0, 0, 0, 32'h0, 32'h0);
        step();
        check("rd_after_wr", last_g, 0);
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        step();
        check("rd20_data", m0_rdata, 32'h55);

        do_reset();
        drive(1, 1, 0, 1, 32'hC, 32'h0);
        for (int c = 0; c < 10; c++) begin
            if (c == 2) drive(0, 1, 0, 0, 32'h18, 32'h0);
            step();
            gl[c] = last_g;
            if (last_g == 0) drive(0, 0, 0, 0, 32'h0, 32'h0);
        end
        for (int c = 0; c < 8; c++) check("burst_m1", gl[c], 1);
        check("burst_handover", gl[8], 0);
        check("burst_regrant", gl[9], 1);

        drive(1, 0, 0, 0, 32'h0, 32'h0);
        do_reset();
        drive(0, 1, 0, 1, 32'h10, 32'h0);
        step();
        reset = 1'b1;
        step();
        check("rst_mid_gnt", last_g, -1);
        reset = 1'b0;
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        step();
        check("rst_mid_rvalid", m0_rvalid, 1'b0);
        drive(0, 1, 0, 0, 32'h0, 32'h0);
        drive(1, 1, 0, 0, 32'h4, 32'h0);
        step();
        check("rst_mid_prio", last_g, 0);

        drive(0, 0, 0, 0, 32'h0, 32'h0);
        drive(1, 0, 0, 0, 32'h0, 32'h0);
        for (int c = 0; c < 5; c++) step();
        check("idle_owner", owner, 2'b00);

        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!rq[i] || last_g == i || reset) begin
                    drive(i, $urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 99) < 40,
                          {26'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom);
                end
            end
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
